// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding APB master.
// Turns a valid/ready command stream into APB SETUP/ACCESS transfers and
// returns PRDATA/PSLVERR on a valid/ready response channel. A PREADY
// timeout aborts a transfer whose slave never answers.
module apb_master_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  // Counter must be able to hold TIMEOUT_CYCLES itself; at least one bit.
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_LIMIT = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES) : {CW{1'b0}};
  localparam logic          TO_EN    = (TIMEOUT_CYCLES > 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] tcnt;
  logic [CW-1:0] tcnt_inc;

  // The bridge takes a command only when idle and out of reset.
  assign cmd_ready = (state == IDLE) && PRESETn;

  // Saturating increment of the wait-state counter; it never wraps.
  always_comb begin
    tcnt_inc = tcnt;
    if (tcnt != {CW{1'b1}}) begin
      tcnt_inc = tcnt + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      tcnt_inc = tcnt;
    end
  end

  // Transfer FSM with all APB and response outputs registered.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state       <= IDLE;
      tcnt        <= {CW{1'b0}};
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= {ADDR_WIDTH{1'b0}};
      PWDATA      <= {DATA_WIDTH{1'b0}};
      rsp_valid   <= 1'b0;
      rsp_rdata   <= {DATA_WIDTH{1'b0}};
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            PWRITE  <= cmd_write;
            PADDR   <= cmd_addr;
            PWDATA  <= cmd_wdata;
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          tcnt    <= {CW{1'b0}};
          state   <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            // Normal completion; PSLVERR only matters on this edge.
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            rsp_rdata   <= PWRITE ? {DATA_WIDTH{1'b0}} : PRDATA;
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end else if (TO_EN && (tcnt_inc == TO_LIMIT)) begin
            // Slave held PREADY low for the full budget: abort.
            tcnt        <= tcnt_inc;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            rsp_rdata   <= {DATA_WIDTH{1'b0}};
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end else begin
            tcnt <= tcnt_inc;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          PSEL      <= 1'b0;
          PENABLE   <= 1'b0;
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed testbench for apb_master_bridge with a small APB slave memory model.
module tb_apb_master_bridge;

  logic        PCLK;
  logic        PRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  logic [31:0] mem [0:15];
  logic        rd_ovr_en;
  logic [31:0] rd_ovr;

  int n_vec = 0;
  int n_err = 0;

  apb_master_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Slave model: completed writes update the memory.
  always @(posedge PCLK) begin
    if (PRESETn && PSEL && PENABLE && PREADY && PWRITE) mem[PADDR[5:2]] <= PWDATA;
  end

  assign PRDATA = rd_ovr_en ? rd_ovr : mem[PADDR[5:2]];

  task automatic tick();
    @(negedge PCLK);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one command for a single edge (bridge is idle, so it is taken).
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("hs_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("hs_cmd_ready", 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    int cnt;
    logic seen;
    logic [31:0] hold_rdata;
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0; cmd_wdata = 32'd0;
    rsp_ready = 1'b0; PREADY = 1'b1; PSLVERR = 1'b0; rd_ovr_en = 1'b0; rd_ovr = 32'd0;
    tick(); tick(); tick();

    // Reset state
    chk("rst_psel", 64'(PSEL), 64'd0);
    chk("rst_penable", 64'(PENABLE), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_paddr", 64'(PADDR), 64'd0);
    chk("rst_pwdata", 64'(PWDATA), 64'd0);
    PRESETn = 1'b1;
    tick();
    chk("rel_cmd_ready", 64'(cmd_ready), 64'd1);

    // Write 0xDEADBEEF to 0, PREADY tied high
    issue(1'b1, 32'h0000_0000, 32'hDEAD_BEEF);
    chk("wr_setup_psel", 64'(PSEL), 64'd1);
    chk("wr_setup_pen", 64'(PENABLE), 64'd0);
    chk("wr_setup_pwrite", 64'(PWRITE), 64'd1);
    chk("wr_setup_pwdata", 64'(PWDATA), 64'hDEAD_BEEF);
    chk("wr_setup_cmd_ready", 64'(cmd_ready), 64'd0);
    tick();
    chk("wr_acc_psel", 64'(PSEL), 64'd1);
    chk("wr_acc_pen", 64'(PENABLE), 64'd1);
    chk("wr_acc_paddr", 64'(PADDR), 64'd0);
    tick();
    chk("wr_done_psel", 64'(PSEL), 64'd0);
    chk("wr_done_pen", 64'(PENABLE), 64'd0);
    chk("wr_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("wr_rsp_err", 64'(rsp_err), 64'd0);
    chk("wr_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("wr_hold_pwdata", 64'(PWDATA), 64'hDEAD_BEEF);
    chk("wr_hold_pwrite", 64'(PWRITE), 64'd1);
    handshake();

    // Read back address 0
    issue(1'b0, 32'h0000_0000, 32'h0);
    chk("rd_setup_pwrite", 64'(PWRITE), 64'd0);
    tick();
    chk("rd_acc_pwrite", 64'(PWRITE), 64'd0);
    tick();
    chk("rd_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("rd_rsp_rdata", 64'(rsp_rdata), 64'hDEAD_BEEF);
    chk("rd_rsp_err", 64'(rsp_err), 64'd0);
    handshake();

    // Wait states: PREADY low for 3 ACCESS samples
    PREADY = 1'b0;
    issue(1'b0, 32'h0000_0000, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ws_pen", 64'(PENABLE), 64'd1);
      chk("ws_paddr", 64'(PADDR), 64'd0);
      chk("ws_rsp_valid", 64'(rsp_valid), 64'd0);
    end
    PREADY = 1'b1;
    tick();
    chk("ws_rsp_valid_up", 64'(rsp_valid), 64'd1);
    chk("ws_pen_down", 64'(PENABLE), 64'd0);
    chk("ws_rsp_timeout", 64'(rsp_timeout), 64'd0);
    chk("ws_rsp_rdata", 64'(rsp_rdata), 64'hDEAD_BEEF);
    handshake();

    // Slave error on read of 0x10, then backpressure for 5 cycles
    rd_ovr_en = 1'b1; rd_ovr = 32'h1234_5678; PSLVERR = 1'b1;
    issue(1'b0, 32'h0000_0010, 32'h0);
    chk("err_paddr", 64'(PADDR), 64'h10);
    tick(); tick();
    rd_ovr_en = 1'b0; PSLVERR = 1'b0;
    chk("err_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("err_rsp_err", 64'(rsp_err), 64'd1);
    chk("err_rsp_timeout", 64'(rsp_timeout), 64'd0);
    chk("err_rsp_rdata", 64'(rsp_rdata), 64'h1234_5678);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_rsp_err", 64'(rsp_err), 64'd1);
      chk("bp_rsp_rdata", 64'(rsp_rdata), 64'h1234_5678);
      chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
    end
    handshake();

    // Timeout: PREADY stuck low
    PREADY = 1'b0;
    issue(1'b1, 32'h0000_0004, 32'h0000_0055);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (PENABLE) cnt++;
      else break;
    end
    chk("to_access_cycles", 64'(cnt), 64'd16);
    chk("to_psel", 64'(PSEL), 64'd0);
    chk("to_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("to_rsp_err", 64'(rsp_err), 64'd1);
    chk("to_rsp_timeout", 64'(rsp_timeout), 64'd1);
    chk("to_rsp_rdata", 64'(rsp_rdata), 64'd0);
    PREADY = 1'b1;
    handshake();

    // Normal write and read after the timeout
    issue(1'b1, 32'h0000_0004, 32'hA5A5_A5A5);
    tick(); tick();
    chk("post_wr_valid", 64'(rsp_valid), 64'd1);
    chk("post_wr_err", 64'(rsp_err), 64'd0);
    chk("post_wr_timeout", 64'(rsp_timeout), 64'd0);
    handshake();
    issue(1'b0, 32'h0000_0004, 32'h0);
    tick(); tick();
    hold_rdata = rsp_rdata;
    chk("post_rd_rdata", 64'(hold_rdata), 64'hA5A5_A5A5);
    handshake();

    // Reset during ACCESS
    PREADY = 1'b0;
    issue(1'b0, 32'h0000_0000, 32'h0);
    tick();
    chk("mr_acc_pen", 64'(PENABLE), 64'd1);
    PRESETn = 1'b0;
    tick();
    chk("mr_psel", 64'(PSEL), 64'd0);
    chk("mr_penable", 64'(PENABLE), 64'd0);
    chk("mr_cmd_ready_low", 64'(cmd_ready), 64'd0);
    PREADY = 1'b1;
    tick();
    PRESETn = 1'b1;
    seen = rsp_valid;
    tick();
    chk("mr_cmd_ready_rel", 64'(cmd_ready), 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      seen = seen | rsp_valid;
    end
    chk("mr_no_rsp", 64'(seen), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Single-outstanding APB master that converts a simple valid/ready command stream into APB SETUP/ACCESS transfers.
- Sits directly upstream of apb_slave and drives its PSEL/PENABLE/PWRITE/PADDR/PWDATA.
- Returns PRDATA/PSLVERR on a valid/ready response channel.
- Adds a PREADY timeout so a hung slave cannot stall the command source.

Parameters:
ADDR_WIDTH, 32, width of cmd_addr/PADDR
DATA_WIDTH, 32, width of data paths
TIMEOUT_CYCLES, 16, max consecutive ACCESS cycles with PREADY low before abort; 0 disables timeout

Ports:
PCLK  in  1  clock, all logic on rising edge
PRESETn  in  1  synchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  bridge can accept command
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_WIDTH  transfer address
cmd_wdata  in  DATA_WIDTH  write data
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  DATA_WIDTH  read data (0 for writes/timeouts)
rsp_err  out  1  PSLVERR seen or timeout
rsp_timeout  out  1  transfer aborted by timeout
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  ADDR_WIDTH  APB address
PWDATA  out  DATA_WIDTH  APB write data
PRDATA  in  DATA_WIDTH  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB slave error

Behaviour:
- Interface fixed: one clock PCLK; reset PRESETn is synchronous and active-low.
- Reset (PRESETn low at a rising edge): state=IDLE; PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, and the timeout counter all 0. cmd_ready is 0 while PRESETn is low and 1 in the first cycle after reset release.
- All outputs are registered. cmd_ready = (state==IDLE) && PRESETn.
- FSM states and transitions:
  - IDLE: on cmd_valid&&cmd_ready at edge N, latch cmd_write/addr/wdata into PWRITE/PADDR/PWDATA and go to SETUP. PSEL=1, PENABLE=0 during cycle N..N+1.
  - SETUP: exactly one cycle. Next edge goes to ACCESS with PSEL=1, PENABLE=1; timeout counter cleared.
  - ACCESS: PREADY sampled high at an edge completes the transfer.
    - PSEL and PENABLE drop to 0 at that same edge.
    - rsp_rdata = PWRITE ? 0 : PRDATA; rsp_err = PSLVERR; rsp_timeout = 0; rsp_valid = 1.
    - Go to RESP.
    - If PREADY is low, increment the counter. When TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES (that many consecutive low samples), abort: PSEL=PENABLE=0, rsp_rdata=0, rsp_err=1, rsp_timeout=1, go to RESP.
  - RESP: hold rsp_valid and all rsp_* stable until rsp_ready is sampled high. Then rsp_valid=0 and go to IDLE.
- Minimum transfer: 4 cycles from accept to next cmd_ready (accept/SETUP, ACCESS, RESP, IDLE). No pipelining, one outstanding transfer.
- PADDR/PWRITE/PWDATA stay stable from SETUP through ACCESS end. After the transfer they hold their last values; they are not zeroed.
- PSLVERR is only sampled when PREADY=1 in ACCESS and is ignored otherwise. PRDATA is ignored on writes.
- rsp_ready high outside RESP has no effect. cmd_valid outside IDLE is ignored; the command stays pending at the source.
- Reset mid-transfer (any state): next edge with PRESETn low forces IDLE and drops PSEL/PENABLE. The in-flight response is discarded and never presented.
- Width rules: the counter is $clog2(TIMEOUT_CYCLES+1) bits, minimum 1. It saturates and must never wrap.

Test Plan:
- Write with PREADY tied 1: cmd 0x0000_0000/0xDEADBEEF accepted at edge N. PSEL=1,PENABLE=0 after N; PENABLE=1 after N+1; PSEL=0 after N+2; rsp_valid=1, rsp_err=0, rsp_rdata=0; PADDR=0, PWDATA=0xDEADBEEF, PWRITE=1 throughout.
- Read back 0x0000_0000 from apb_slave: rsp_rdata=0xDEADBEEF, rsp_err=0, PWRITE=0 during SETUP/ACCESS.
- Wait states: slave holds PREADY low 3 cycles in ACCESS. PENABLE stays high 4 cycles, address/data stable, rsp_valid rises the edge after PREADY=1, rsp_timeout=0.
- Slave error: PREADY=1 with PSLVERR=1 on read of 0x0000_0010, PRDATA=0x1234_5678. Response: rsp_err=1, rsp_timeout=0, rsp_rdata=0x1234_5678.
- Timeout (TIMEOUT_CYCLES=16): PREADY held 0. Exactly 16 ACCESS cycles, then PSEL/PENABLE=0, rsp_err=1, rsp_timeout=1, rsp_rdata=0. A following command then completes normally.
- Backpressure and reset:
  - rsp_ready low 5 cycles: rsp_* stable, cmd_ready=0 until the handshake.
  - Second run: PRESETn low during ACCESS. PSEL/PENABLE=0 next edge, no rsp_valid ever, cmd_ready=1 the first cycle after release.
